// File: rtl/me_pkg.sv
// Shared motion-estimation constants and helpers used across the ME array blocks.
package me_pkg;
  localparam int PIX_W_DEF = 8;

  // Bits needed to hold a full SAD over blk_pix pixels without overflow.
  function automatic int sad_width(input int pix_w, input int blk_pix);
    return pix_w + $clog2(blk_pix);
  endfunction
endpackage

// File: rtl/me_absdiff.sv
// Combinational unsigned absolute difference; shared with the SAD-tree blocks.
module me_absdiff #(
  parameter int PIX_W = me_pkg::PIX_W_DEF
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] d
);
  assign d = (a >= b) ? a - b : b - a;
endmodule

// File: rtl/me_pe_sad.sv
// ME array processing element: current-pixel slot store, neighbour reference
// register, registered |cur-ref| and a saturating per-candidate SAD accumulator.
module me_pe_sad
  import me_pkg::*;
#(
  parameter  int PIX_W   = PIX_W_DEF,
  parameter  int SLOTS   = 8,
  parameter  int REF_SRC = 4,
  parameter  int ACC_W   = sad_width(PIX_W_DEF, 256),
  localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int RW      = (REF_SRC > 1) ? $clog2(REF_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIX_W-1:0]         cur_in,
  input  logic                     cur_we,
  input  logic [SW-1:0]            cur_wslot,
  input  logic [SW-1:0]            cur_rslot,
  output logic [PIX_W-1:0]         cur_out,
  input  logic [REF_SRC*PIX_W-1:0] ref_src,
  input  logic [RW-1:0]            ref_sel,
  input  logic                     ref_en,
  output logic [PIX_W-1:0]         ref_out,
  input  logic                     cmp_en,
  input  logic [SW-1:0]            cmp_slot,
  input  logic                     cmp_last,
  input  logic                     acc_clr,
  output logic [PIX_W-1:0]         abs_out,
  output logic                     abs_valid,
  output logic [ACC_W-1:0]         sad_out,
  output logic                     sad_valid,
  output logic                     sad_sat
);
  logic [SLOTS-1:0][PIX_W-1:0] slot_q;
  logic [PIX_W-1:0]            cmp_pix, ref_mux, abs_d;
  logic                        last_q, sat_q, sat_base, ovf;
  logic [ACC_W-1:0]            acc_q, acc_base, sum;
  logic [ACC_W:0]              sum_full;

  // Out-of-range slot indices read as 0; out-of-range ref_sel falls back to source 0.
  always_comb begin
    cur_out = '0;
    cmp_pix = '0;
    ref_mux = ref_src[PIX_W-1:0];
    for (int i = 0; i < SLOTS; i++) begin
      if (cur_rslot == SW'(i)) cur_out = slot_q[i];
      if (cmp_slot == SW'(i))  cmp_pix = slot_q[i];
    end
    for (int i = 0; i < REF_SRC; i++)
      if (ref_sel == RW'(i)) ref_mux = ref_src[i*PIX_W +: PIX_W];
  end

  me_absdiff #(.PIX_W(PIX_W)) u_absdiff (
    .a(cmp_pix),
    .b(ref_out),
    .d(abs_d)
  );

  // acc_clr lets a coincident sample seed the new sum instead of being dropped.
  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    sat_base = acc_clr ? 1'b0 : sat_q;
    sum_full = {1'b0, acc_base} + (ACC_W+1)'(abs_out);
    ovf      = sum_full[ACC_W];
    sum      = ovf ? '1 : sum_full[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      ref_out <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++)
        if (cur_we && cur_wslot == SW'(i)) slot_q[i] <= cur_in;
      if (ref_en) ref_out <= ref_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_out   <= '0;
      abs_valid <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      abs_valid <= cmp_en;
      if (cmp_en) begin
        abs_out <= abs_d;
        last_q  <= cmp_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
      sad_sat   <= 1'b0;
    end else begin
      sad_valid <= 1'b0;
      if (abs_valid && last_q) begin
        sad_out   <= sum;
        sad_sat   <= sat_base | ovf;
        sad_valid <= 1'b1;
        acc_q     <= '0;
        sat_q     <= 1'b0;
      end else if (abs_valid) begin
        acc_q <= sum;
        sat_q <= sat_base | ovf;
      end else begin
        acc_q <= acc_base;
        sat_q <= sat_base;
      end
    end
  end
endmodule

// File: tb/tb_me_pe_sad.sv
// Bench for me_pe_sad: default-parameter PE and a small-config PE (SLOTS=6,
// REF_SRC=3, ACC_W=9) driven by shared stimulus against a sum-based model.
module tb_me_pe_sad;
  logic        clk, rst_n;
  logic [7:0]  cur_in;
  logic        cur_we;
  logic [2:0]  cur_wslot, cur_rslot, cmp_slot;
  logic [31:0] ref_src;
  logic [1:0]  ref_sel;
  logic        ref_en, cmp_en, cmp_last, acc_clr;

  logic [7:0]  cur_o0, cur_o1, ref_o0, ref_o1, abs_o0, abs_o1;
  logic        abs_v0, abs_v1, sad_v0, sad_v1, sat0, sat1;
  logic [15:0] sad_o0;
  logic [8:0]  sad_o1;

  int n_chk = 0, n_bad = 0;

  me_pe_sad dut0 (
    .clk(clk), .rst_n(rst_n), .cur_in(cur_in), .cur_we(cur_we), .cur_wslot(cur_wslot),
    .cur_rslot(cur_rslot), .cur_out(cur_o0), .ref_src(ref_src), .ref_sel(ref_sel),
    .ref_en(ref_en), .ref_out(ref_o0), .cmp_en(cmp_en), .cmp_slot(cmp_slot),
    .cmp_last(cmp_last), .acc_clr(acc_clr), .abs_out(abs_o0), .abs_valid(abs_v0),
    .sad_out(sad_o0), .sad_valid(sad_v0), .sad_sat(sat0)
  );

  me_pe_sad #(.PIX_W(8), .SLOTS(6), .REF_SRC(3), .ACC_W(9)) dut1 (
    .clk(clk), .rst_n(rst_n), .cur_in(cur_in), .cur_we(cur_we), .cur_wslot(cur_wslot),
    .cur_rslot(cur_rslot), .cur_out(cur_o1), .ref_src(ref_src[23:0]), .ref_sel(ref_sel),
    .ref_en(ref_en), .ref_out(ref_o1), .cmp_en(cmp_en), .cmp_slot(cmp_slot),
    .cmp_last(cmp_last), .acc_clr(acc_clr), .abs_out(abs_o1), .abs_valid(abs_v1),
    .sad_out(sad_o1), .sad_valid(sad_v1), .sad_sat(sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-instance slot contents, reference, and the true (unclipped)
  // running total of the candidate; saturation is derived from the total.
  int m_slot[2][8];
  int m_ref[2], e_abs[2], total[2], e_sad[2];
  bit e_av[2], p_l[2], e_sv[2], e_sat[2];

  function automatic int nsl(int k);  return (k == 0) ? 8 : 6; endfunction
  function automatic int nsrc(int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int smax(int k); return (k == 0) ? 65535 : 511; endfunction
  function automatic int rd(int k, int idx);
    return (idx < nsl(k)) ? m_slot[k][idx] : 0;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mreset(input int k);
    for (int i = 0; i < 8; i++) m_slot[k][i] = 0;
    m_ref[k] = 0; e_abs[k] = 0; total[k] = 0; e_sad[k] = 0;
    e_av[k] = 0; p_l[k] = 0; e_sv[k] = 0; e_sat[k] = 0;
  endtask

  task automatic mstep(input int k);
    int base, t, a, sel;
    base = acc_clr ? 0 : total[k];
    e_sv[k] = 0;
    total[k] = base;
    if (e_av[k]) begin
      t = base + e_abs[k];
      if (p_l[k]) begin
        e_sad[k] = (t > smax(k)) ? smax(k) : t;
        e_sat[k] = (t > smax(k));
        e_sv[k] = 1;
        total[k] = 0;
      end else total[k] = t;
    end
    if (cmp_en) begin
      a = rd(k, int'(cmp_slot));
      e_abs[k] = (a > m_ref[k]) ? a - m_ref[k] : m_ref[k] - a;
      p_l[k] = cmp_last;
    end
    e_av[k] = cmp_en;
    if (cur_we && int'(cur_wslot) < nsl(k)) m_slot[k][cur_wslot] = int'(cur_in);
    if (ref_en) begin
      sel = (int'(ref_sel) < nsrc(k)) ? int'(ref_sel) : 0;
      m_ref[k] = int'(ref_src[sel*8 +: 8]);
    end
  endtask

  task automatic check_dut(input int k);
    int av, ao, sv, so, ss, ro, co;
    if (k == 0) begin
      av = int'(abs_v0); ao = int'(abs_o0); sv = int'(sad_v0); so = int'(sad_o0);
      ss = int'(sat0); ro = int'(ref_o0); co = int'(cur_o0);
    end else begin
      av = int'(abs_v1); ao = int'(abs_o1); sv = int'(sad_v1); so = int'(sad_o1);
      ss = int'(sat1); ro = int'(ref_o1); co = int'(cur_o1);
    end
    chk($sformatf("d%0d_abs_valid", k), av, int'(e_av[k]));
    chk($sformatf("d%0d_abs_out", k), ao, e_abs[k]);
    chk($sformatf("d%0d_sad_valid", k), sv, int'(e_sv[k]));
    chk($sformatf("d%0d_sad_out", k), so, e_sad[k]);
    chk($sformatf("d%0d_sad_sat", k), ss, int'(e_sat[k]));
    chk($sformatf("d%0d_ref_out", k), ro, m_ref[k]);
    chk($sformatf("d%0d_cur_out", k), co, rd(k, int'(cur_rslot)));
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) mreset(k);
      else mstep(k);
    end
    #1;
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  task automatic idle();
    cur_we = 0; ref_en = 0; cmp_en = 0; cmp_last = 0; acc_clr = 0;
  endtask

  task automatic wr(input int slot, input int val);
    idle();
    cur_we = 1; cur_wslot = 3'(slot); cur_in = 8'(val);
    cyc();
    cur_we = 0;
  endtask

  task automatic cmp(input int slot, input bit last, input bit clr);
    idle();
    cmp_en = 1; cmp_slot = 3'(slot); cmp_last = last; acc_clr = clr;
    cyc();
  endtask

  int ex_abs[8] = '{25, 15, 5, 5, 15, 25, 35, 45};

  initial begin
    idle();
    cur_in = 0; cur_wslot = 0; cur_rslot = 0; cmp_slot = 0; ref_src = 0; ref_sel = 0;
    rst_n = 0;
    for (int k = 0; k < 2; k++) mreset(k);
    cyc(); cyc();
    rst_n = 1;

    // Ramp slots against ref source 2 = 35
    for (int i = 0; i < 8; i++) wr(i, 10 * (i + 1));
    ref_src = {8'd0, 8'd35, 8'd0, 8'd0}; ref_sel = 2; ref_en = 1;
    cyc();
    chk("ref_sel2", int'(ref_o0), 35);
    for (int i = 0; i < 8; i++) begin
      cmp(i, i == 7, 0);
      chk($sformatf("abs_seq%0d", i), int'(abs_o0), ex_abs[i]);
    end
    idle(); cyc();
    chk("sad170_valid", int'(sad_v0), 1);
    chk("sad170", int'(sad_o0), 170);

    // Slot write while comparing the same slot uses the old value
    wr(3, 10);
    ref_src = 0; ref_sel = 0; ref_en = 1; cyc(); idle();
    cur_we = 1; cur_wslot = 3; cur_in = 50; cmp_en = 1; cmp_slot = 3;
    cyc();
    chk("wr_cmp_old", int'(abs_o0), 10);
    cmp(3, 0, 0);
    chk("wr_cmp_new", int'(abs_o0), 50);
    idle(); cyc();

    // acc_clr coincident with a sample: seeds the new sum / completes it
    wr(0, 100); wr(1, 7); wr(2, 0);
    cmp(0, 0, 1);
    cmp(1, 0, 0);
    cmp(2, 1, 1);
    idle(); cyc();
    chk("clr_seed_sad", int'(sad_o0), 7);
    cmp(0, 0, 0);
    cmp(1, 1, 0);
    idle(); acc_clr = 1; cyc();
    chk("clr_last_valid", int'(sad_v0), 1);
    chk("clr_last_sad", int'(sad_o0), 7);
    idle();

    // Saturation on the 9-bit instance, then a clean candidate
    wr(0, 255);
    for (int i = 0; i < 16; i++) cmp(0, i == 15, 0);
    idle(); cyc();
    chk("sat_sad9", int'(sad_o1), 511);
    chk("sat_flag9", int'(sat1), 1);
    chk("nosat_sad16", int'(sad_o0), 4080);
    cmp(1, 1, 0);
    idle(); cyc();
    chk("post_sat_sad", int'(sad_o1), 7);
    chk("post_sat_flag", int'(sat1), 0);

    // Out-of-range ref_sel and slot index on the small instance
    idle();
    cur_we = 1; cur_wslot = 7; cur_in = 99; cur_rslot = 7;
    ref_src = {8'h44, 8'h33, 8'h22, 8'h11}; ref_sel = 3; ref_en = 1;
    cyc();
    chk("refsel_oob", int'(ref_o1), 8'h11);
    chk("refsel3", int'(ref_o0), 8'h44);
    chk("slot7_oob", int'(cur_o1), 0);
    chk("slot7", int'(cur_o0), 99);

    // Reset mid-candidate with a last sample in flight
    cmp(0, 0, 0); cmp(1, 0, 0); cmp(2, 1, 0);
    idle();
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin mreset(k); check_dut(k); end
    chk("rst_abs_valid", int'(abs_v0), 0);
    chk("rst_sad_out", int'(sad_o0), 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_sad", int'(sad_v0) + int'(sad_v1), 0);
    end

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cur_we    = ($urandom_range(0, 3) == 0);
      cur_wslot = 3'($urandom_range(0, 7));
      cur_rslot = 3'($urandom_range(0, 7));
      cur_in    = 8'($urandom_range(0, 255));
      ref_src   = $urandom;
      ref_sel   = 2'($urandom_range(0, 3));
      ref_en    = ($urandom_range(0, 3) == 0);
      cmp_en    = ($urandom_range(0, 4) != 0);
      cmp_slot  = 3'($urandom_range(0, 7));
      cmp_last  = ($urandom_range(0, 7) == 0);
      acc_clr   = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/me_pe_sad.md
# me_pe_sad

Parametrised processing element for the HEVC integer motion-estimation array. It stores up to SLOTS current-block pixels and selects a reference pixel from REF_SRC neighbour links. It produces a registered absolute difference and accumulates a saturating partial SAD per search candidate. It replaces the fixed 8-slot/4-source PE in the systolic ME array and adds the pipelined SAD accumulator with a last-pixel result strobe.

## Interface
- PIX_W, 8, pixel width in bits
- SLOTS, 8, current-block pixel registers (≥1)
- REF_SRC, 4, reference neighbour inputs (≥1)
- ACC_W, 16, SAD accumulator width (≥PIX_W+1)
- SW = max(1,$clog2(SLOTS)), RW = max(1,$clog2(REF_SRC)): derived localparams

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cur_in  in  PIX_W  current-frame pixel to load
- cur_we  in  1  write cur_in into slot cur_wslot
- cur_wslot  in  SW  write slot index
- cur_rslot  in  SW  pass-through read slot index
- cur_out  out  PIX_W  slot[cur_rslot], combinational, to next PE in chain
- ref_src  in  REF_SRC*PIX_W  neighbour reference pixels, source i at bits [i*PIX_W +: PIX_W]
- ref_sel  in  RW  reference source select
- ref_en  in  1  load selected source into ref_out
- ref_out  out  PIX_W  registered reference pixel, to neighbours
- cmp_en  in  1  compare slot cmp_slot against ref_out this cycle
- cmp_slot  in  SW  slot used for comparison
- cmp_last  in  1  qualifies cmp_en: final pixel of the candidate
- acc_clr  in  1  discard partial SAD and sticky saturation
- abs_out  out  PIX_W  registered |cur − ref|
- abs_valid  out  1  abs_out valid
- sad_out  out  ACC_W  completed SAD, held until next completion
- sad_valid  out  1  one-cycle completion strobe
- sad_sat  out  1  sad_out saturated

## Operation
- Slot store: on cur_we, slot[cur_wslot] <= cur_in. A cur_wslot ≥ SLOTS is ignored. Reads of an index ≥ SLOTS return 0.
- Reference: on ref_en, ref_out <= ref_src[ref_sel]. A ref_sel ≥ REF_SRC selects source 0. Without ref_en, ref_out holds.
- Stage 1: on cmp_en, abs_out <= |slot[cmp_slot] − ref_out|, abs_valid <= 1, and last_q <= cmp_last. Otherwise abs_valid <= 0 and abs_out holds. Operands are unsigned PIX_W, compared without wrap.
- Stage 2: sum = acc + abs_out, saturating at 2^ACC_W−1. Saturation sets sat_q.
  - On abs_valid with !last_q: acc <= sum.
  - On abs_valid with last_q: sad_out <= sum, sad_sat <= sat_q | overflow, sad_valid <= 1. acc <= 0 and sat_q <= 0.
- acc_clr: acc <= 0 and sat_q <= 0. If abs_valid is in the same cycle, the current sample starts the new sum: acc <= abs_out, or it completes immediately if last_q.
- Simultaneous events:
  - cur_we to the slot being compared: the comparison uses the old value.
  - ref_en with cmp_en: the comparison uses the old ref_out.
  - acc_clr does not affect stage 1.

## Timing
- Reset values: ref_out, abs_out, abs_valid, sad_out, sad_valid, sad_sat, acc, sat_q, last_q are all 0. All slots are 0, so cur_out = 0.
- Latency: cmp_en at cycle t gives abs_valid at t+1. cmp_en with cmp_last at t gives sad_valid at t+2.
- Throughput: one comparison per cycle; back-to-back candidates need no bubbles.
- Reset asserted mid-candidate clears all state immediately. No sad_valid follows for the aborted candidate.

## Structure
- Shared package me_pkg holds the default PIX_W and an SAD width helper function (PIX_W + $clog2(block pixels)).
- Sub-module me_absdiff: combinational unsigned |a−b|, parameter PIX_W. It is reused by later SAD-tree blocks.

## Test plan
- Reset mid-stream: assert rst_n low during an accumulation -> all outputs 0 at once, no sad_valid afterwards.
- Load slots 0..7 with 10,20,…,80; ref_en with ref_sel=2 and ref_src[2]=35; cmp_en on slots 0..7, cmp_last on slot 7 -> abs_out sequence 25,15,5,5,15,25,35,45, then sad_out=170 with sad_valid at t+2.
- ACC_W=9, PIX_W=8: sixteen samples of |255−0| with last on the final one -> sad_out=511, sad_sat=1; next candidate starts from 0 with sad_sat=0.
- acc_clr in the same cycle as abs_valid=7 after a partial sum of 100 -> acc=7. With last asserted instead -> sad_out=7.
- Write slot 3 = 50 while comparing slot 3 (old value 10) with ref 0 -> abs_out=10. Next comparison -> 50.
- REF_SRC=3, ref_sel=3 -> ref_out = source 0. SLOTS=6: write to slot 7 is ignored and cur_rslot=7 gives cur_out=0.
